// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit retired per clock,
// signed or unsigned operands, registered product with a one-cycle done pulse.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned EW   = WIDTH + 2;
  localparam int unsigned AW   = 2 * WIDTH + 2;
  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned CW   = $clog2(HALF + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [AW-1:0] xs;     // multiplicand, pre-shifted to the current digit weight
  logic [EW:0]   ybits;  // extended multiplier with the implicit y[-1]=0 at bit 0
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;

  logic          sx_c;
  logic          sy_c;
  logic [2:0]    trip_c;
  logic [AW-1:0] pp_c;
  logic [AW-1:0] sum_c;

  // Booth digit decode and accumulate; arithmetic wraps modulo 2^AW
  always_comb begin
    sx_c   = is_signed & x[WIDTH-1];
    sy_c   = is_signed & y[WIDTH-1];
    trip_c = ybits[2:0];
    pp_c   = '0;
    case (trip_c)
      3'b001, 3'b010: pp_c = xs;
      3'b011:         pp_c = xs << 1;
      3'b100:         pp_c = -(xs << 1);
      3'b101, 3'b110: pp_c = -xs;
      default:        pp_c = '0;
    endcase
    sum_c = acc + pp_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      cnt   <= '0;
      acc   <= '0;
      xs    <= '0;
      ybits <= '0;
      last  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            xs    <= {{(AW-WIDTH){sx_c}}, x};
            ybits <= {{2{sy_c}}, y, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            // unsigned needs one extra digit to consume the zero-extended top bits
            last  <= is_signed ? CW'(HALF - 1) : CW'(HALF);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= sum_c;
          xs    <= xs << 2;
          ybits <= ybits >> 2;
          cnt   <= cnt + CW'(1);
          if (cnt == last) begin
            p     <= sum_c[2*WIDTH-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq at WIDTH=32 and WIDTH=8: directed vector table,
// multi-cycle corner sequences, and random operands against a plain-multiply model.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, is_signed, busy, done;
  logic [31:0] x, y;
  logic [63:0] p;

  logic        rst8, start8, sgn8, busy8, done8;
  logic [7:0]  x8, y8;
  logic [15:0] p8;

  booth_mult_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .x(x), .y(y), .busy(busy), .done(done), .p(p)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .is_signed(sgn8),
    .x(x8), .y(y8), .busy(busy8), .done(done8), .p(p8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint ea, eb;
    ea = s ? longint'($signed(a)) : longint'({32'b0, a});
    eb = s ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(ea * eb);
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ea, eb;
    ea = s ? int'($signed(a)) : int'({24'b0, a});
    eb = s ? int'($signed(b)) : int'({24'b0, b});
    return 16'(ea * eb);
  endfunction

  // Latency counts negedges from the one where start is driven to the one where done is seen.
  task automatic run32(input logic [31:0] xi, input logic [31:0] yi, input logic si,
                       output logic [63:0] pr, output int lat);
    @(negedge clk);
    x = xi; y = yi; is_signed = si; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    pr = p;
  endtask

  task automatic run8(input logic [7:0] xi, input logic [7:0] yi, input logic si,
                      output logic [15:0] pr, output int lat);
    @(negedge clk);
    x8 = xi; y8 = yi; sgn8 = si; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    pr = p8;
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic [63:0] p;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [63:0] pr, first;
    int          lat, lat2;
    logic        seen, hold;

    tbl[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 17};
    tbl[1] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 17};
    tbl[2] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000, 17};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 18};
    tbl[4] = '{32'h00000007, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFFFFFFFFEB, 17};
    tbl[5] = '{32'h00000000, 32'h12345678, 1'b0, 64'h0000000000000000, 18};
    tbl[6] = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000, 18};
    tbl[7] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000, 17};
    tbl[8] = '{32'h00000003, 32'h00000005, 1'b0, 64'h000000000000000F, 18};

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; x = '0; y = '0;
    rst8 = 1'b1; start8 = 1'b0; sgn8 = 1'b0; x8 = '0; y8 = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_p", p, 64'd0);
    check("reset_p8", 64'(p8), 64'd0);
    rst = 1'b0; rst8 = 1'b0;

    // directed vectors, including one-cycle done pulse
    for (int i = 0; i < 9; i++) begin
      run32(tbl[i].x, tbl[i].y, tbl[i].s, pr, lat);
      check($sformatf("vec%0d_p", i), pr, tbl[i].p);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      check($sformatf("vec%0d_idle_busy", i), 64'(busy), 64'd0);
      check($sformatf("vec%0d_p_hold", i), p, tbl[i].p);
    end

    // start pulsed mid-run with different operands is ignored
    @(negedge clk);
    x = 32'h10; y = 32'h20; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    check("midrun_busy", 64'(busy), 64'd1);
    repeat (3) begin @(negedge clk); lat++; end
    x = 32'h3; y = 32'h3; is_signed = 1'b1; start = 1'b1;
    @(negedge clk);
    lat++; start = 1'b0; x = 32'hDEADBEEF; y = 32'h12345678;
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    check("midrun_p", p, 64'h200);
    check("midrun_lat", 64'(lat), 64'd18);

    // reset at run cycle 5 aborts with no done pulse
    @(negedge clk);
    x = 32'h5; y = 32'h6; is_signed = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstrun_busy", 64'(busy), 64'd0);
    check("rstrun_done", 64'(done), 64'd0);
    check("rstrun_p", p, 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin @(negedge clk); if (done) seen = 1'b1; end
    check("rstrun_no_done", 64'(seen), 64'd0);
    run32(32'd6, 32'd7, 1'b0, pr, lat);
    check("after_rst_p", pr, 64'd42);
    check("after_rst_lat", 64'(lat), 64'd18);

    // back-to-back: start held through DONE with new operands
    @(negedge clk);
    x = 32'h80000000; y = 32'h1; is_signed = 1'b1; start = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done && lat < 60);
    first = p;
    check("b2b_first_p", first, 64'hFFFFFFFF80000000);
    check("b2b_first_lat", 64'(lat), 64'd17);
    x = 32'd7; y = 32'hFFFFFFFD; is_signed = 1'b1;
    @(negedge clk);
    check("b2b_accept_busy", 64'(busy), 64'd1);
    check("b2b_accept_done", 64'(done), 64'd0);
    start = 1'b0; lat2 = 1; hold = 1'b1;
    while (!done && lat2 < 60) begin
      if (p !== 64'hFFFFFFFF80000000) hold = 1'b0;
      @(negedge clk);
      lat2++;
    end
    check("b2b_p_held", 64'(hold), 64'd1);
    check("b2b_second_lat", 64'(lat2), 64'd17);
    check("b2b_second_p", p, 64'hFFFFFFFFFFFFFFEB);

    // random operands in both modes, both widths concurrently
    fork
      begin
        logic [31:0] xr, yr;
        logic        sr;
        logic [63:0] pq;
        int          lq;
        for (int i = 0; i < 2000; i++) begin
          xr = $urandom; yr = $urandom; sr = 1'($urandom_range(0, 1));
          if (i % 16 == 0) xr = 32'h80000000;
          if (i % 16 == 1) yr = 32'h80000000;
          run32(xr, yr, sr, pq, lq);
          check($sformatf("rnd32_p x=%h y=%h s=%0d", xr, yr, sr), pq, ref32(xr, yr, sr));
          check("rnd32_lat", 64'(lq), sr ? 64'd17 : 64'd18);
        end
      end
      begin
        logic [7:0]  xr, yr;
        logic        sr;
        logic [15:0] pq;
        int          lq;
        for (int i = 0; i < 5000; i++) begin
          xr = 8'($urandom); yr = 8'($urandom); sr = 1'($urandom_range(0, 1));
          run8(xr, yr, sr, pq, lq);
          check($sformatf("rnd8_p x=%h y=%h s=%0d", xr, yr, sr), 64'(pq), 64'(ref8(xr, yr, sr)));
          check("rnd8_lat", 64'(lq), sr ? 64'd5 : 64'd6);
        end
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
